ifetch_queue: RTL
=================

// Module: ifetch_queue
// PURPOSE
//  Instruction fetch front end feeding the CPU decode stage. Owns the fetch PC and issues
//  in-order word reads to instruction memory over a valid/ready request, in-order response bus.
//  Buffers up to DEPTH fetched {pc, inst} pairs for decode. Flushes on branch/jump redirect.
// PARAMETERS
//  DEPTH     4      queue entries; also the cap on queued plus in-flight fetches (power of 2, >=2)
//  ADDR_W    32     fetch address width
//  DATA_W    32     instruction width
//  RESET_PC  'h0    first fetch address after reset
// PORTS
//  CLK             in   1       clock, rising edge
//  rst             in   1       synchronous reset, active-high
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       memory accepts request
//  imem_req_addr   out  ADDR_W  word-aligned fetch address
//  imem_rsp_valid  in   1       response valid; max one per cycle; in request order; >=1 cycle after accept
//  imem_rsp_data   in   DATA_W  fetched instruction
//  redirect_valid  in   1       branch/jump taken; flush and refetch
//  redirect_addr   in   ADDR_W  new fetch PC; bits [1:0] forced to 0
//  inst_valid      out  1       queue head valid
//  inst_ready      in   1       decode consumes head
//  inst_data       out  DATA_W  head instruction
//  inst_pc         out  ADDR_W  head instruction address
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, state=RST; all valids 0.
//  - FSM: RST -> RUN (always, 1 cycle after rst deasserts); RUN -> FLUSH on redirect while
//    outstanding>0 (after this cycle's accounting); FLUSH -> RUN when discard reaches 0.
//    Redirect in FLUSH reloads discard.
//  - Request: imem_req_valid = (state!=RST) && (count+outstanding < DEPTH); addr = fetch_pc.
//    Accept (valid&&ready): fetch_pc += 4, wraps 'hFFFF_FFFC -> 0; outstanding++.
//  - Response: outstanding--. If discard>0: drop, discard--. Else push {addr, data} to queue.
//    Addr comes from a pc-tag FIFO written on accept, which is never flushed.
//    Credit rule guarantees the queue cannot overflow.
//  - Dequeue: inst_valid = count>0; head pops on inst_valid&&inst_ready; outputs registered
//    from queue storage. Empty->valid latency: response cycle +1.
//  - Redirect (priority over everything in same cycle):
//      queue cleared (a pop in the same cycle still counts as consumed);
//      fetch_pc = redirect_addr & ~3;
//      discard = outstanding after this cycle's accept/response (same-cycle response dropped,
//      same-cycle accept counted stale);
//      a request in the redirect cycle still issues the OLD pc and is discarded.
//  - Simultaneous push and pop with count==DEPTH is legal; count unchanged.
//  - Reset mid-operation clears everything next edge. Instruction memory shares rst;
//    responses while rst=1 are ignored.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined:
//    adds outputs perf_fetch_cnt[31:0] (accepted requests) and perf_flush_cnt[31:0]
//    (redirects) and perf_drop_cnt[31:0] (discarded responses); reset 0; saturating.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ifetch_pkg: fsm enum {RST, RUN, FLUSH}, INST_BYTES=4 constant, ifq_entry_t struct {pc, inst}.
//  One sub-module: ifq_fifo (synchronous FIFO of ifq_entry_t, params DEPTH,
//  push/pop/flush/count). Used for both the pc-tag FIFO (never flushed) and the inst queue.
// TESTING
//  1 Reset, ready=1, rsp latency 1, inst_ready=1 -> inst_pc 0,4,8,C...;
//    first inst_valid 3 cycles after rst falls.
//  2 inst_ready=0 for 20 cycles -> exactly 4 requests accepted, then imem_req_valid=0;
//    count<=4; drain yields 0,4,8,C in order.
//  3 Redirect to 'h200 with 2 in flight -> both responses dropped;
//    next inst_pc='h200, then 'h204.
//  4 redirect_addr='h103 -> first new request addr 'h100.
//  5 Redirect coincident with pop and response -> popped entry consumed, response dropped,
//    queue empty next cycle.
//  6 Fetch from 'hFFFF_FFF8 -> addrs FFF8, FFFC, 0000.
//    rst mid-stream -> all valids 0 next cycle, restart at RESET_PC.
//    With IFETCH_PERF_CNT_EN: check counters equal scenario totals.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch queue: FSM encoding, queue entry layout
// and the fetch stride.
package ifetch_pkg;

   localparam int IFQ_ADDR_W = 32;
   localparam int IFQ_DATA_W = 32;
   localparam int INST_BYTES = 4;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } ifetch_state_e;

   typedef struct packed {
      logic [IFQ_ADDR_W-1:0] pc;
      logic [IFQ_DATA_W-1:0] inst;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of DEPTH entries of type T (power-of-two depth). A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module ifq_fifo
   import ifetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = ifq_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output T                       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

   T                 mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_pop_s;
   logic             do_push_s;

   assign do_pop_s  = pop && (count_r != {(PTR_W+1){1'b0}});
   assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
   assign head      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping; flush empties the FIFO without touching storage.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited in-order fetch with redirect flush.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = IFQ_ADDR_W,
   parameter int                DATA_W   = IFQ_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              CLK,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt,
   output logic [31:0]       perf_drop_cnt
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   ifetch_state_e     state_r;
   ifetch_state_e     state_next_s;
   logic [ADDR_W-1:0] fetch_pc_r;
   logic [CNT_W-1:0]  discard_r;
   logic [CNT_W-1:0]  discard_next_s;
   logic [CNT_W-1:0]  q_count_s;
   logic [CNT_W-1:0]  outstanding_s;
   logic [CNT_W-1:0]  outstanding_next_s;
   logic [CNT_W:0]    inflight_s;
   logic              accept_s;
   logic              rsp_s;
   logic              drop_s;
   logic              push_s;
   logic              pop_s;
   ifq_entry_t        push_entry_s;
   ifq_entry_t        head_s;
   logic [ADDR_W-1:0] tag_head_s;

   // Queued plus in-flight fetches never exceed DEPTH, so every response has a slot.
   assign inflight_s     = {1'b0, q_count_s} + {1'b0, outstanding_s};
   assign imem_req_valid = (state_r != ST_RST) && (inflight_s < (CNT_W+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_r;

   assign accept_s = imem_req_valid && imem_req_ready;
   assign rsp_s    = imem_rsp_valid;
   assign drop_s   = rsp_s && ((discard_r != CNT_ZERO) || redirect_valid);
   assign push_s   = rsp_s && !drop_s;
   assign pop_s    = inst_valid && inst_ready;

   assign outstanding_next_s = outstanding_s + {{(CNT_W-1){1'b0}}, accept_s}
                                             - {{(CNT_W-1){1'b0}}, rsp_s};

   assign push_entry_s.pc   = IFQ_ADDR_W'(tag_head_s);
   assign push_entry_s.inst = IFQ_DATA_W'(imem_rsp_data);

   assign inst_valid = (q_count_s != CNT_ZERO);
   assign inst_data  = DATA_W'(head_s.inst);
   assign inst_pc    = ADDR_W'(head_s.pc);

   // Discard bookkeeping and FSM next state; a redirect makes everything still in flight stale.
   always_comb begin
      discard_next_s = discard_r;
      state_next_s   = state_r;
      if (redirect_valid) begin
         discard_next_s = outstanding_next_s;
      end else if (rsp_s && (discard_r != CNT_ZERO)) begin
         discard_next_s = discard_r - CNT_ONE;
      end else begin
         discard_next_s = discard_r;
      end
      case (state_r)
         ST_RST:   state_next_s = ST_RUN;
         ST_RUN,
         ST_FLUSH: state_next_s = (discard_next_s != CNT_ZERO) ? ST_FLUSH : ST_RUN;
         default:  state_next_s = ST_RST;
      endcase
   end

   // Fetch PC, discard counter and FSM state.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_r    <= ST_RST;
         fetch_pc_r <= RESET_PC;
         discard_r  <= CNT_ZERO;
      end else begin
         state_r   <= state_next_s;
         discard_r <= discard_next_s;
         if (redirect_valid) begin
            fetch_pc_r <= {redirect_addr[ADDR_W-1:2], 2'b00};
         end else if (accept_s) begin
            fetch_pc_r <= fetch_pc_r + ADDR_W'(INST_BYTES);
         end else begin
            fetch_pc_r <= fetch_pc_r;
         end
      end
   end

   // The tag FIFO occupancy is the outstanding-request count; it must survive redirects.
   ifq_fifo #(
      .DEPTH (DEPTH),
      .T     (logic [ADDR_W-1:0])
   ) u_tag_fifo (
      .clk       (CLK),
      .rst       (rst),
      .push      (accept_s),
      .push_data (fetch_pc_r),
      .pop       (rsp_s),
      .flush     (1'b0),
      .head      (tag_head_s),
      .count     (outstanding_s)
   );

   ifq_fifo #(
      .DEPTH (DEPTH),
      .T     (ifq_entry_t)
   ) u_inst_fifo (
      .clk       (CLK),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .flush     (redirect_valid),
      .head      (head_s),
      .count     (q_count_s)
   );

`ifdef IFETCH_PERF_CNT_EN
   // Saturating event counters.
   always_ff @(posedge CLK) begin
      if (rst) begin
         perf_fetch_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
         perf_drop_cnt  <= 32'd0;
      end else begin
         if (accept_s && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
         if (drop_s && (perf_drop_cnt != 32'hFFFF_FFFF)) begin
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
